// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file constants and ABI register indices
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  localparam reg_addr_t ZERO_REG = 5'd0;
  localparam int NREGS_I = 32;
  localparam int NREGS_E = 16;
  localparam reg_addr_t RA = 5'd1;
  localparam reg_addr_t SP = 5'd2;
  localparam reg_addr_t GP = 5'd3;
  localparam reg_addr_t TP = 5'd4;
  localparam reg_addr_t T0 = 5'd5;
  localparam reg_addr_t T1 = 5'd6;
  localparam reg_addr_t T2 = 5'd7;
  localparam reg_addr_t S0 = 5'd8;
  localparam reg_addr_t S1 = 5'd9;
  localparam reg_addr_t A0 = 5'd10;
  localparam reg_addr_t A1 = 5'd11;
  localparam reg_addr_t A2 = 5'd12;
  localparam reg_addr_t A3 = 5'd13;
  localparam reg_addr_t A4 = 5'd14;
  localparam reg_addr_t A5 = 5'd15;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: load-pending bits, busy lookup and sticky WAW error
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_pend_set,
  input  reg_addr_t i_pend_addr,
  input  logic      i_wb_en,
  input  reg_addr_t i_wb_addr,
  input  logic      i_wa_en,
  input  reg_addr_t i_wa_addr,
  input  reg_addr_t i_rs1_addr,
  input  reg_addr_t i_rs2_addr,
  output logic      o_rs1_busy,
  output logic      o_rs2_busy,
  output logic      o_err_waw
);
  logic [NREGS-1:1] r_pend;
  logic             r_err;
  logic             w_waw;
  // a new load issued as the old one returns keeps the bit set
  always_ff @(posedge clk or posedge rst)
    if (rst) r_pend <= '0;
    else
      for (int i = 1; i < NREGS; i++)
        r_pend[i] <= (i_pend_set && i_pend_addr == 5'(i)) ||
                     (r_pend[i] && !(i_wb_en && i_wb_addr == 5'(i)));
  // err_waw is sticky until reset
  always_ff @(posedge clk or posedge rst)
    if (rst) r_err <= 1'b0;
    else r_err <= r_err | w_waw;
  // busy lookup; x0 and out-of-range addresses never match a pending bit
  always_comb begin
    o_rs1_busy = 1'b0;
    o_rs2_busy = 1'b0;
    w_waw      = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      o_rs1_busy = o_rs1_busy | (i_rs1_addr == 5'(i) && r_pend[i]);
      o_rs2_busy = o_rs2_busy | (i_rs2_addr == 5'(i) && r_pend[i]);
      w_waw      = w_waw | (i_wa_en && i_wa_addr == 5'(i) && r_pend[i]);
    end
    if (BYPASS && i_wb_en && i_wb_addr == i_rs1_addr) o_rs1_busy = 1'b0;
    if (BYPASS && i_wb_en && i_wb_addr == i_rs2_addr) o_rs2_busy = 1'b0;
    if (i_wb_en && i_wb_addr == i_wa_addr) w_waw = 1'b0;
  end
  assign o_err_waw = r_err;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: two-write-port register file with bypass and load scoreboard
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  reg_addr_t       rs1_addr,
  input  reg_addr_t       rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wa_en,
  input  reg_addr_t       wa_addr,
  input  logic [XLEN-1:0] wa_data,
  input  logic            wb_en,
  input  reg_addr_t       wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            pend_set,
  input  reg_addr_t       pend_addr,
  output logic            err_waw
);
  logic [XLEN-1:0] r_regs [1:NREGS-1];
  logic            w_wa_byp;
  logic            w_wb_byp;
  // while in reset the write ports must not leak onto the read ports
  assign w_wa_byp = BYPASS && wa_en && !rst;
  assign w_wb_byp = BYPASS && wb_en && !rst;
  // port A is checked first so the younger ALU result wins a collision
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
    else
      for (int i = 1; i < NREGS; i++)
        if (wa_en && wa_addr == 5'(i)) r_regs[i] <= wa_data;
        else if (wb_en && wb_addr == 5'(i)) r_regs[i] <= wb_data;
  // read muxes; only x1..x(NREGS-1) can match, everything else reads zero
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (rs1_addr == 5'(i))
        rs1_data = (w_wa_byp && wa_addr == rs1_addr) ? wa_data :
                   (w_wb_byp && wb_addr == rs1_addr) ? wb_data : r_regs[i];
      if (rs2_addr == 5'(i))
        rs2_data = (w_wa_byp && wa_addr == rs2_addr) ? wa_data :
                   (w_wb_byp && wb_addr == rs2_addr) ? wb_data : r_regs[i];
    end
  end
  rf_scoreboard #(.NREGS(NREGS), .BYPASS(BYPASS)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_pend_set (pend_set),
    .i_pend_addr(pend_addr),
    .i_wb_en    (wb_en),
    .i_wb_addr  (wb_addr),
    .i_wa_en    (wa_en),
    .i_wa_addr  (wa_addr),
    .i_rs1_addr (rs1_addr),
    .i_rs2_addr (rs2_addr),
    .o_rs1_busy (rs1_busy),
    .o_rs2_busy (rs2_busy),
    .o_err_waw  (err_waw)
  );
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: model-checked bench over RV32I/bypass, RV32E/bypass and RV32I/no-bypass
module tb_reg_file_mp;
  logic        clk, rst;
  logic [4:0]  rs1_addr, rs2_addr, wa_addr, wb_addr, pend_addr;
  logic [31:0] wa_data, wb_data;
  logic        wa_en, wb_en, pend_set;
  logic [31:0] d1 [3];
  logic [31:0] d2 [3];
  logic        b1 [3];
  logic        b2 [3];
  logic        e  [3];
  logic [31:0] m  [3][32];
  bit          p  [3][32];
  bit          me [3];
  int          n_chk, n_fail;

  reg_file_mp #(.NREGS(32), .BYPASS(1)) u_i (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(d1[0]), .rs2_data(d2[0]), .rs1_busy(b1[0]), .rs2_busy(b2[0]),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .err_waw(e[0]));
  reg_file_mp #(.NREGS(16), .BYPASS(1)) u_e (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(d1[1]), .rs2_data(d2[1]), .rs1_busy(b1[1]), .rs2_busy(b2[1]),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .err_waw(e[1]));
  reg_file_mp #(.NREGS(32), .BYPASS(0)) u_n (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(d1[2]), .rs2_data(d2[2]), .rs1_busy(b1[2]), .rs2_busy(b2[2]),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .err_waw(e[2]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic bit legal(int c, logic [4:0] a);
    return a != 5'd0 && int'(a) < (c == 1 ? 16 : 32);
  endfunction

  function automatic logic [31:0] exp_data(int c, logic [4:0] a);
    if (rst || !legal(c, a)) return 32'd0;
    if (c != 2 && wa_en && wa_addr == a) return wa_data;
    if (c != 2 && wb_en && wb_addr == a) return wb_data;
    return m[c][a];
  endfunction

  function automatic logic exp_busy(int c, logic [4:0] a);
    if (rst || !legal(c, a)) return 1'b0;
    if (c != 2 && wb_en && wb_addr == a) return 1'b0;
    return p[c][a];
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        me[c] = 0;
        for (int r = 0; r < 32; r++) begin
          m[c][r] = 0;
          p[c][r] = 0;
        end
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (wa_en && legal(c, wa_addr) && p[c][wa_addr] && !(wb_en && wb_addr == wa_addr)) me[c] = 1;
        if (wb_en && legal(c, wb_addr)) begin
          m[c][wb_addr] = wb_data;
          p[c][wb_addr] = 0;
        end
        if (wa_en && legal(c, wa_addr)) m[c][wa_addr] = wa_data;
        if (pend_set && legal(c, pend_addr)) p[c][pend_addr] = 1;
      end
    end

  task automatic chk(string n, int c, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d t=%0t got=%h want=%h", n, c, $time, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst)
      for (int c = 0; c < 3; c++) begin
        chk("rs1_data", c, d1[c], exp_data(c, rs1_addr));
        chk("rs2_data", c, d2[c], exp_data(c, rs2_addr));
        chk("rs1_busy", c, 32'(b1[c]), 32'(exp_busy(c, rs1_addr)));
        chk("rs2_busy", c, 32'(b2[c]), 32'(exp_busy(c, rs2_addr)));
        chk("err_waw", c, 32'(e[c]), 32'(me[c]));
      end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wa_en = 0;
    wb_en = 0;
    pend_set = 0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1;
    idle();
    rs1_addr = 0; rs2_addr = 0; wa_addr = 0; wb_addr = 0; pend_addr = 0;
    wa_data = 0; wb_data = 0;
    #2;
    chk("rst_d1", 0, d1[0], 32'd0);
    chk("rst_b1", 0, 32'(b1[0]), 32'd0);
    chk("rst_err", 0, 32'(e[0]), 32'd0);
    tick();
    tick();
    rst = 0;
    wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF; rs1_addr = 5;
    #1;
    chk("x5_byp", 0, d1[0], 32'hDEADBEEF);
    chk("x5_nobyp", 2, d1[2], 32'd0);
    tick();
    idle();
    #1;
    chk("x5_rd", 0, d1[0], 32'hDEADBEEF);
    chk("x5_rd", 1, d1[1], 32'hDEADBEEF);
    chk("x5_rd", 2, d1[2], 32'hDEADBEEF);
    tick();
    wa_en = 1; wa_addr = 0; wa_data = 32'h1234; rs1_addr = 0;
    #1;
    chk("x0_byp", 0, d1[0], 32'd0);
    tick();
    idle();
    #1;
    chk("x0_rd", 0, d1[0], 32'd0);
    tick();
    wa_en = 1; wa_addr = 7; wa_data = 32'hAAAA0000;
    wb_en = 1; wb_addr = 7; wb_data = 32'h5555FFFF; rs1_addr = 7;
    #1;
    chk("coll_byp", 0, d1[0], 32'hAAAA0000);
    chk("coll_nobyp", 2, d1[2], 32'd0);
    tick();
    idle();
    #1;
    chk("coll_rd", 0, d1[0], 32'hAAAA0000);
    chk("coll_rd", 2, d1[2], 32'hAAAA0000);
    tick();
    pend_set = 1; pend_addr = 9; rs2_addr = 9;
    #1;
    chk("pend_same", 0, 32'(b2[0]), 32'd0);
    tick();
    idle();
    #1;
    chk("pend_next", 0, 32'(b2[0]), 32'd1);
    tick();
    wb_en = 1; wb_addr = 9; wb_data = 32'h42;
    #1;
    chk("ld_busy", 0, 32'(b2[0]), 32'd0);
    chk("ld_data", 0, d2[0], 32'h42);
    chk("ld_busy", 2, 32'(b2[2]), 32'd1);
    chk("ld_data", 2, d2[2], 32'd0);
    tick();
    idle();
    #1;
    chk("ld_busy_after", 2, 32'(b2[2]), 32'd0);
    chk("ld_data_after", 2, d2[2], 32'h42);
    tick();
    pend_set = 1; pend_addr = 9; wb_en = 1; wb_addr = 9; wb_data = 32'h77;
    tick();
    idle();
    #1;
    chk("setclr_busy", 0, 32'(b2[0]), 32'd1);
    chk("setclr_data", 0, d2[0], 32'h77);
    chk("err_before", 0, 32'(e[0]), 32'd0);
    tick();
    wa_en = 1; wa_addr = 9; wa_data = 32'h99;
    tick();
    idle();
    #1;
    chk("waw_set", 0, 32'(e[0]), 32'd1);
    chk("waw_set", 2, 32'(e[2]), 32'd1);
    chk("waw_data", 0, d2[0], 32'h99);
    tick();
    wb_en = 1; wb_addr = 9; wb_data = 32'h5;
    tick();
    idle();
    repeat (3) tick();
    chk("waw_sticky", 0, 32'(e[0]), 32'd1);
    wa_en = 1; wa_addr = 20; wa_data = 32'hFFFFFFFF; pend_set = 1; pend_addr = 20; rs1_addr = 20;
    #1;
    chk("x20_byp_e", 1, d1[1], 32'd0);
    tick();
    idle();
    #1;
    chk("x20_e", 1, d1[1], 32'd0);
    chk("x20_busy_e", 1, 32'(b1[1]), 32'd0);
    chk("x20_i", 0, d1[0], 32'hFFFFFFFF);
    chk("x20_busy_i", 0, 32'(b1[0]), 32'd1);
    wa_en = 1; wa_addr = 15; wa_data = 32'h123; rs1_addr = 15;
    tick();
    idle();
    #1;
    chk("x15_e", 1, d1[1], 32'h123);
    wa_en = 1; wa_addr = 5; wa_data = 32'h1111;
    wb_en = 1; wb_addr = 6; wb_data = 32'h2222;
    rs1_addr = 5; rs2_addr = 20;
    #2;
    rst = 1;
    #1;
    chk("rst_mid_d1", 0, d1[0], 32'd0);
    chk("rst_mid_b2", 0, 32'(b2[0]), 32'd0);
    chk("rst_mid_err", 0, 32'(e[0]), 32'd0);
    chk("rst_mid_d1", 2, d1[2], 32'd0);
    tick();
    idle();
    tick();
    rst = 0;
    #1;
    chk("post_rst_x5", 0, d1[0], 32'd0);
    wa_en = 1; wa_addr = 3; wa_data = 32'h3333; rs1_addr = 3;
    tick();
    idle();
    #1;
    chk("first_wr", 2, d1[2], 32'h3333);
    for (int k = 0; k < 300; k++) begin
      tick();
      wa_en = 1'($urandom); wa_addr = 5'($urandom_range(0, 20));
      wb_en = 1'($urandom); wb_addr = 5'($urandom_range(0, 20));
      pend_set = 1'($urandom); pend_addr = 5'($urandom_range(0, 20));
      wa_data = $urandom; wb_data = $urandom;
      rs1_addr = 5'($urandom_range(0, 20)); rs2_addr = 5'($urandom_range(0, 31));
    end
    tick();
    idle();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
